contador_bcd: RTL and testbench
===============================

# contador_bcd

Registered multi-digit BCD up/down counter that generates the BCD digits consumed by the 7-segment decoder stage, one decoder per digit (HEX0..HEX(NDIG-1)). Counting runs from an internal prescaler tick or from a single-step pulse. It also supports a synchronous parallel load from switches and a one-cycle carry/borrow pulse on wrap. Every BCD nibble it emits is always in the range 0..9, so the downstream decoder never needs its blank (default) case.

## Interface
- DIV, 50000000: prescaler period in CLOCK_50 cycles (1 Hz at 50 MHz); must be ≥ 2.
- NDIG, 4: number of BCD digits (1..8).
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  enables the prescaler and tick-driven counting.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load request.
- load_val  in  4*NDIG  value to load; digit i at [4i+3:4i], digit 0 is least significant.
- step  in  1  single-step request, already synchronized and debounced; rising edge is used.
- bcd  out  4*NDIG  current count; digit i at [4i+3:4i].
- tick  out  1  one-cycle prescaler pulse.
- carry  out  1  one-cycle pulse when the count wraps.

## Operation
- Priority order per cycle: reset > load > count event.
- reset=1: bcd=0, tick=0, carry=0, prescaler=0, step history=0.
- load=1:
  - bcd takes load_val, with each digit greater than 9 saturated to 9.
  - prescaler is cleared to 0.
  - carry=0. tick=0. No count happens in that cycle.
  - The step history register still samples step.
- Prescaler:
  - When en=1, it counts 0..DIV-1. At DIV-1 it returns to 0 and tick=1 on the next cycle.
  - When en=0, it holds its value and tick=0.
- Step edge: step_rise = step & ~step_q, where step_q is step registered each cycle.
- Count event: (tick_internal & en) | step_rise. A tick and a step edge in the same cycle produce exactly one count.
- Count event with up=1:
  - Digit 0 increments. A digit at 9 becomes 0 and propagates a carry to the next digit (ripple, same cycle).
  - If all digits are 9, the count becomes all 0 and carry=1.
- Count event with up=0:
  - Digit 0 decrements. A digit at 0 becomes 9 and propagates a borrow.
  - If all digits are 0, the count becomes all 9 and carry=1.
- carry is 0 in every cycle without a wrap.
- up may change on any cycle; the value sampled in the cycle of the count event applies.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- tick is high for exactly one cycle per DIV cycles of en=1.
- A count event in cycle N produces the new bcd in cycle N+1. carry is asserted in cycle N+1 together with the wrapped value.
- A tick-driven count updates bcd in the same cycle tick is visible on the output. Both come from the same prescaler state at cycle N.
- A step rising edge sampled in cycle N updates bcd in cycle N+1. Holding step high produces no further counts.
- load sampled in cycle N: bcd=load_val (saturated) in cycle N+1. The first tick after that arrives DIV cycles after the first en=1 cycle that follows.
- A reset asserted mid-count takes effect on the next edge, with all state cleared. No carry pulse is emitted at reset.
- en dropping low during the cycle the prescaler is at DIV-1 suppresses that tick. The prescaler then holds at DIV-1 and fires on the first cycle en returns high.

## Structure
- Shared package/include bcd_pkg holds:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - BCD_ZERO = 4'd0
  - the default DIV constant
- The decoder stage uses the same package.
- Sub-module digito_bcd (one instance per digit):
  - Inputs: up, cin (carry/borrow enable in).
  - Outputs: digit value, cout. cout is asserted when the digit wraps with cin=1.
  - Also handles load with saturation.
- The top module contains:
  - the prescaler
  - step edge detection
  - the cascade of NDIG digito_bcd instances
  - carry register, where carry = the registered cout of the last digit

## Test plan
- Reset then count up: DIV=4, NDIG=2, en=1, up=1 for 40 cycles.
  - Required: tick every 4 cycles, bcd steps 00→01→…→09→10, no carry.
- Up wrap: load 0x99, then one step edge.
  - Required: bcd=0x00 and carry=1 for exactly one cycle, in the cycle after the edge.
- Down wrap and borrow: load 0x10, up=0, two step edges.
  - Required: bcd=0x09, then 0x08, with no carry.
  - Then load 0x00 and one step edge. Required: bcd=0x99 and carry=1.
- Load saturation and priority: load=1 with load_val=0xAF in the same cycle as tick and a step edge.
  - Required: bcd=0x99 next cycle, no count, carry=0, prescaler cleared.
- Simultaneous events and hold: a tick and a step edge in the same cycle.
  - Required: the count advances by exactly 1.
  - Then hold step high for 10 cycles with en=0. Required: bcd unchanged, tick=0.
- Mid-operation reset: reset during counting at bcd=0x57.
  - Required: next cycle bcd=0x00, tick=0, carry=0.
  - The first tick after release occurs 4 cycles after release (DIV=4, en=1).

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the counter and the 7-segment decoder stage.
package bcd_pkg;

  localparam int unsigned BCD_W       = 4;
  localparam logic [3:0]  BCD_MAX     = 4'd9;
  localparam logic [3:0]  BCD_ZERO    = 4'd0;
  localparam int unsigned DIV_DEFAULT = 50_000_000;

  // Clamp a raw nibble into the legal BCD range so downstream decoders never see 10..15.
  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/digito_bcd.sv
// One BCD digit of the cascade: up/down step on cin, saturating load, wrap flag out.
module digito_bcd
  import bcd_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  input  logic             up_i,
  input  logic             cin_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             cout_c_o
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;
  logic             wrap_c;

  // Load wins over counting; cout only fires when this digit actually steps across its limit.
  always_comb begin
    digit_d  = digit_q;
    wrap_c   = 1'b0;
    cout_c_o = 1'b0;
    if (load_i) begin
      digit_d = bcd_sat(load_val_i);
    end else if (cin_i) begin
      if (up_i) begin
        wrap_c  = (digit_q == BCD_MAX);
        digit_d = wrap_c ? BCD_ZERO : digit_q + BCD_W'(1);
      end else begin
        wrap_c  = (digit_q == BCD_ZERO);
        digit_d = wrap_c ? BCD_MAX : digit_q - BCD_W'(1);
      end
      cout_c_o = wrap_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/contador_bcd.sv
// Multi-digit BCD up/down counter driven by a prescaler tick or a single-step edge,
// with saturating parallel load and a one-cycle wrap pulse.
module contador_bcd
  import bcd_pkg::*;
#(
  parameter int unsigned DIV  = DIV_DEFAULT,
  parameter int unsigned NDIG = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [BCD_W*NDIG-1:0] load_val,
  input  logic                  step,
  output logic [BCD_W*NDIG-1:0] bcd,
  output logic                  tick,
  output logic                  carry
);

  localparam int unsigned   PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick_q;
  logic          tick_d;
  logic          carry_q;
  logic          carry_d;
  logic          step_q;

  logic          presc_wrap_c;
  logic          step_rise_c;
  logic          count_c;
  logic [NDIG:0] chain_c;

  assign presc_wrap_c = (presc_q == PRESC_LAST);
  assign step_rise_c  = step & ~step_q;

  // A tick and a step edge in the same cycle merge into a single count event.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    count_c = 1'b0;
    carry_d = 1'b0;
    if (load) begin
      presc_d = '0;
    end else begin
      if (en) begin
        presc_d = presc_wrap_c ? '0 : presc_q + PW'(1);
        tick_d  = presc_wrap_c;
      end
      count_c = (presc_wrap_c & en) | step_rise_c;
      carry_d = chain_c[NDIG];
    end
  end

  assign chain_c[0] = count_c;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    digito_bcd u_dig (
      .clk_i      (CLOCK_50),
      .reset_i    (reset),
      .load_i     (load),
      .load_val_i (load_val[BCD_W*i +: BCD_W]),
      .up_i       (up),
      .cin_i      (chain_c[i]),
      .digit_o    (bcd[BCD_W*i +: BCD_W]),
      .cout_c_o   (chain_c[i+1])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
      step_q  <= step;
    end
  end

  assign tick  = tick_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_contador_bcd.sv
// Bench for contador_bcd (DIV=4, NDIG=2): directed corners, a load table and random traffic vs. an integer model.
module tb_contador_bcd;

  localparam int unsigned DIV  = 4;
  localparam int unsigned NDIG = 2;
  localparam int unsigned W    = 4 * NDIG;
  localparam int          MOD  = 100;

  logic         CLOCK_50 = 1'b0;
  logic         reset, en, up, load, step;
  logic [W-1:0] load_val;
  logic [W-1:0] bcd;
  logic         tick, carry;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: count as a plain decimal integer, prescaler as an integer phase.
  int m_val   = 0;
  int m_presc = 0;
  bit m_tick  = 1'b0;
  bit m_carry = 1'b0;
  bit m_stepq = 1'b0;

  typedef struct {
    logic [W-1:0] lv;
    logic [W-1:0] exp;
  } load_vec_t;

  contador_bcd #(.DIV(DIV), .NDIG(NDIG)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .step     (step),
    .bcd      (bcd),
    .tick     (tick),
    .carry    (carry)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int sat_dec(input logic [W-1:0] lv);
    int r, p, d;
    r = 0;
    p = 1;
    for (int i = 0; i < NDIG; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      r += d * p;
      p *= 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model with the inputs now applied, take one clock edge, compare all outputs.
  task automatic cycle();
    bit rise, wrap;
    if (reset) begin
      m_val = 0; m_presc = 0; m_tick = 0; m_carry = 0; m_stepq = 0;
    end else begin
      rise    = step && !m_stepq;
      m_stepq = step;
      if (load) begin
        m_val = sat_dec(load_val); m_presc = 0; m_tick = 0; m_carry = 0;
      end else begin
        wrap    = en && (m_presc == int'(DIV) - 1);
        m_tick  = wrap;
        m_carry = 0;
        if (en) m_presc = (m_presc + 1) % int'(DIV);
        if (wrap || rise) begin
          if (up) begin
            m_val++;
            if (m_val == MOD) begin m_val = 0; m_carry = 1; end
          end else if (m_val == 0) begin
            m_val = MOD - 1; m_carry = 1;
          end else begin
            m_val--;
          end
        end
      end
    end
    @(posedge CLOCK_50);
    #1;
    check("model_bcd",   32'(bcd),   32'(to_bcd(m_val)));
    check("model_tick",  32'(tick),  32'(m_tick));
    check("model_carry", 32'(carry), 32'(m_carry));
  endtask

  task automatic wait_presc_last();
    for (int k = 0; k < 2 * int'(DIV) && m_presc != int'(DIV) - 1; k++) cycle();
    check("presc_reach", 32'(m_presc), 32'(DIV - 1));
  endtask

  task automatic tick_latency(input string name);
    int lat;
    lat = 0;
    for (int k = 0; k < 3 * int'(DIV); k++) begin
      cycle();
      lat++;
      if (tick) break;
    end
    check(name, 32'(lat), 32'(DIV));
  endtask

  load_vec_t lvec[6];
  int ticks, carries;

  initial begin
    lvec[0] = '{8'hAF, 8'h99};
    lvec[1] = '{8'h5A, 8'h59};
    lvec[2] = '{8'h37, 8'h37};
    lvec[3] = '{8'hF0, 8'h90};
    lvec[4] = '{8'h09, 8'h09};
    lvec[5] = '{8'hBC, 8'h99};

    reset = 1; en = 0; up = 1; load = 0; step = 0; load_val = '0;
    cycle();
    cycle();
    check("rst_bcd",   32'(bcd),   32'h0);
    check("rst_tick",  32'(tick),  32'h0);
    check("rst_carry", 32'(carry), 32'h0);

    // Count up from reset: one tick per DIV cycles, 40 cycles -> 10.
    reset = 0; en = 1; up = 1;
    ticks = 0; carries = 0;
    repeat (40) begin
      cycle();
      ticks += int'(tick);
      carries += int'(carry);
    end
    check("up_ticks",   32'(ticks),   32'd10);
    check("up_carries", 32'(carries), 32'd0);
    check("up_bcd",     32'(bcd),     32'h10);

    // Up wrap from 99.
    en = 0; load = 1; load_val = 8'h99;
    cycle();
    load = 0; step = 1;
    cycle();
    check("upwrap_bcd",   32'(bcd),   32'h00);
    check("upwrap_carry", 32'(carry), 32'h1);
    cycle();
    check("upwrap_carry_off", 32'(carry), 32'h0);
    step = 0;
    cycle();

    // Down with borrow, then down wrap from 00.
    load = 1; load_val = 8'h10; up = 0;
    cycle();
    load = 0; step = 1;
    cycle();
    check("down_09", 32'(bcd), 32'h09);
    check("down_09_carry", 32'(carry), 32'h0);
    step = 0;
    cycle();
    step = 1;
    cycle();
    check("down_08", 32'(bcd), 32'h08);
    step = 0; load = 1; load_val = 8'h00;
    cycle();
    load = 0; step = 1;
    cycle();
    check("downwrap_bcd",   32'(bcd),   32'h99);
    check("downwrap_carry", 32'(carry), 32'h1);
    step = 0; up = 1;
    cycle();

    // Saturating load table.
    for (int i = 0; i < 6; i++) begin
      load = 1; load_val = lvec[i].lv;
      cycle();
      check($sformatf("load_tbl%0d", i), 32'(bcd), 32'(lvec[i].exp));
    end
    load = 0;
    cycle();

    // Load beats a simultaneous tick and step edge; prescaler restarts.
    en = 1; step = 0;
    wait_presc_last();
    load = 1; load_val = 8'hAF; step = 1;
    cycle();
    check("prio_bcd",   32'(bcd),   32'h99);
    check("prio_tick",  32'(tick),  32'h0);
    check("prio_carry", 32'(carry), 32'h0);
    load = 0; step = 0;
    tick_latency("prio_tick_latency");

    // Tick and step edge together count once; then step held high with en=0.
    load = 1; load_val = 8'h42;
    cycle();
    load = 0;
    wait_presc_last();
    step = 1;
    cycle();
    check("simul_bcd",  32'(bcd),  32'h43);
    check("simul_tick", 32'(tick), 32'h1);
    en = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("hold_bcd",  32'(bcd),  32'h43);
      check("hold_tick", 32'(tick), 32'h0);
    end
    step = 0;

    // Reset in the middle of counting.
    en = 1; load = 1; load_val = 8'h57;
    cycle();
    load = 0;
    cycle();
    check("pre_rst_bcd", 32'(bcd), 32'h57);
    reset = 1;
    cycle();
    check("midrst_bcd",   32'(bcd),   32'h0);
    check("midrst_tick",  32'(tick),  32'h0);
    check("midrst_carry", 32'(carry), 32'h0);
    reset = 0;
    tick_latency("midrst_tick_latency");

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      reset    = ($urandom_range(0, 79) == 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = W'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      up       = 1'($urandom_range(0, 1));
      step     = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
